// File: rtl/io_pkg.sv
// Shared constants for the MEM-stage I/O responder: region base, register byte offsets
// and TCTRL bit positions.
package io_pkg;

    localparam logic [23:0] IO_BASE = 24'hFFFFFF;

    localparam logic [7:0] IO_SW     = 8'h80;
    localparam logic [7:0] IO_KEY    = 8'h84;
    localparam logic [7:0] IO_LED    = 8'h88;
    localparam logic [7:0] IO_HEX    = 8'h8C;
    localparam logic [7:0] IO_CYCLE  = 8'h90;
    localparam logic [7:0] IO_TCTRL  = 8'h94;
    localparam logic [7:0] IO_TLOAD  = 8'h98;
    localparam logic [7:0] IO_TCOUNT = 8'h9C;

    localparam int unsigned TC_EN   = 0;
    localparam int unsigned TC_AUTO = 1;
    localparam int unsigned TC_EXP  = 2;

endpackage

// File: rtl/io_timer.sv
// Down-counting timer: TLOAD, TCOUNT and TCTRL (EN/AUTO/EXP) with expiry and auto-reload.
module io_timer
    import io_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        i_wr_tctrl,
    input  logic        i_wr_tload,
    input  logic [31:0] i_wdata,
    output logic [2:0]  o_tctrl,
    output logic [31:0] o_tload,
    output logic [31:0] o_tcount
);

    logic        r_en;
    logic        r_auto;
    logic        r_exp;
    logic [31:0] r_tload;
    logic [31:0] r_tcount;

    logic        w_expire;
    logic        w_en_nxt;
    logic        w_auto_nxt;
    logic        w_exp_nxt;
    logic [31:0] w_tcount_nxt;

    always_comb begin
        w_expire = r_en && (r_tcount == '0);

        // A TLOAD write overrides whatever the counter would have done this edge.
        w_tcount_nxt = r_tcount;
        if (i_wr_tload) begin
            w_tcount_nxt = i_wdata;
        end else if (r_en) begin
            if (r_tcount != '0) begin
                w_tcount_nxt = r_tcount - 32'd1;
            end else if (r_auto) begin
                w_tcount_nxt = r_tload;
            end
        end

        w_en_nxt   = r_en;
        w_auto_nxt = r_auto;
        if (i_wr_tctrl) begin
            w_en_nxt   = i_wdata[TC_EN];
            w_auto_nxt = i_wdata[TC_AUTO];
        end else if (w_expire && !r_auto) begin
            w_en_nxt = 1'b0;
        end

        w_exp_nxt = w_expire | (r_exp & ~(i_wr_tctrl & i_wdata[TC_EXP]));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_en     <= 1'b0;
            r_auto   <= 1'b0;
            r_exp    <= 1'b0;
            r_tload  <= '0;
            r_tcount <= '0;
        end else begin
            r_en     <= w_en_nxt;
            r_auto   <= w_auto_nxt;
            r_exp    <= w_exp_nxt;
            r_tcount <= w_tcount_nxt;
            if (i_wr_tload) begin
                r_tload <= i_wdata;
            end
        end
    end

    always_comb begin
        o_tctrl          = '0;
        o_tctrl[TC_EN]   = r_en;
        o_tctrl[TC_AUTO] = r_auto;
        o_tctrl[TC_EXP]  = r_exp;
    end

    assign o_tload  = r_tload;
    assign o_tcount = r_tcount;

endmodule

// File: rtl/pipe_io_responder.sv
// Memory-mapped I/O register file on the MEM-stage data bus (switches, keys, LEDs, hex, cycle
// counter). The timer block at 0x94-0x9C exists only when IO_TIMER_EN is defined.
module pipe_io_responder
    import io_pkg::*;
#(
    parameter int unsigned SW_W  = 10,
    parameter int unsigned KEY_W = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              mwmem,
    input  logic [31:0]       malu,
    input  logic [31:0]       mb,
    output logic              io_sel,
    output logic [31:0]       io_rdata,
    input  logic [SW_W-1:0]   sw,
    input  logic [KEY_W-1:0]  key,
    output logic [SW_W-1:0]   led,
    output logic [23:0]       hex,
    output logic              timer_irq
);

    logic [SW_W-1:0]  r_sw_s1;
    logic [SW_W-1:0]  r_sw_s2;
    logic [KEY_W-1:0] r_key_s1;
    logic [KEY_W-1:0] r_key_s2;
    logic [KEY_W-1:0] r_kflag;
    logic [SW_W-1:0]  r_led;
    logic [23:0]      r_hex;
    logic [31:0]      r_cycle;

    logic [5:0]       w_idx;
    logic             w_wr;
    logic [KEY_W-1:0] w_key_rise;
    logic [2:0]       w_tctrl;
    logic [31:0]      w_tload;
    logic [31:0]      w_tcount;
    logic             w_unused;

    assign io_sel = (malu[31:8] == IO_BASE);
    assign w_idx  = malu[7:2];
    assign w_wr   = mwmem & io_sel;

    // Key is active-low: s2 still released while s1 already pressed means the press becomes
    // visible at this edge, so the sticky flag is set together with it.
    assign w_key_rise = r_key_s2 & ~r_key_s1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_key_s1 <= '1;
            r_key_s2 <= '1;
            r_kflag  <= '0;
            r_led    <= '0;
            r_hex    <= '0;
            r_cycle  <= '0;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_key_s1 <= key;
            r_key_s2 <= r_key_s1;
            r_cycle  <= r_cycle + 32'd1;
            if (w_wr && w_idx == IO_KEY[7:2]) begin
                r_kflag <= (r_kflag & ~mb[2*KEY_W-1:KEY_W]) | w_key_rise;
            end else begin
                r_kflag <= r_kflag | w_key_rise;
            end
            if (w_wr && w_idx == IO_LED[7:2]) begin
                r_led <= mb[SW_W-1:0];
            end
            if (w_wr && w_idx == IO_HEX[7:2]) begin
                r_hex <= mb[23:0];
            end
        end
    end

`ifdef IO_TIMER_EN
    io_timer u_timer (
        .clock      (clock),
        .resetn     (resetn),
        .i_wr_tctrl (w_wr && w_idx == IO_TCTRL[7:2]),
        .i_wr_tload (w_wr && w_idx == IO_TLOAD[7:2]),
        .i_wdata    (mb),
        .o_tctrl    (w_tctrl),
        .o_tload    (w_tload),
        .o_tcount   (w_tcount)
    );
`else
    assign w_tctrl  = '0;
    assign w_tload  = '0;
    assign w_tcount = '0;
`endif

    always_comb begin
        io_rdata = '0;
        if (io_sel) begin
            case (w_idx)
                IO_SW[7:2]:     io_rdata = 32'(r_sw_s2);
                IO_KEY[7:2]:    io_rdata = 32'({r_kflag, ~r_key_s2});
                IO_LED[7:2]:    io_rdata = 32'(r_led);
                IO_HEX[7:2]:    io_rdata = 32'(r_hex);
                IO_CYCLE[7:2]:  io_rdata = r_cycle;
                IO_TCTRL[7:2]:  io_rdata = 32'(w_tctrl);
                IO_TLOAD[7:2]:  io_rdata = w_tload;
                IO_TCOUNT[7:2]: io_rdata = w_tcount;
                default:        io_rdata = '0;
            endcase
        end
    end

    assign led       = r_led;
    assign hex       = r_hex;
    assign timer_irq = w_tctrl[TC_EXP];

    // Byte-lane bits and store-data bits that no register consumes.
    assign w_unused = ^{malu[1:0], mb};

endmodule

// File: tb/tb_pipe_io_responder.sv
// Randomized bench for pipe_io_responder against a behavioural register-map model; covers the
// timer when IO_TIMER_EN is defined, otherwise checks that the timer space is inert.
module tb_pipe_io_responder;

    localparam int unsigned SW_W  = 10;
    localparam int unsigned KEY_W = 4;

    logic              clock  = 1'b0;
    logic              resetn = 1'b0;
    logic              mwmem  = 1'b0;
    logic [31:0]       malu   = '0;
    logic [31:0]       mb     = '0;
    logic              io_sel;
    logic [31:0]       io_rdata;
    logic [SW_W-1:0]   sw     = '0;
    logic [KEY_W-1:0]  key    = '1;
    logic [SW_W-1:0]   led;
    logic [23:0]       hex;
    logic              timer_irq;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [SW_W-1:0]  m_led;
    logic [23:0]      m_hex;
    logic [31:0]      m_cycle;
    logic [SW_W-1:0]  sw_hist[$];
    logic [KEY_W-1:0] key_hist[$];
    logic [KEY_W-1:0] m_flags;
    logic [31:0]      m_tload;
    logic [31:0]      m_tcount;
    logic             m_en;
    logic             m_auto;
    logic             m_exp;

    pipe_io_responder #(
        .SW_W  (SW_W),
        .KEY_W (KEY_W)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .mwmem     (mwmem),
        .malu      (malu),
        .mb        (mb),
        .io_sel    (io_sel),
        .io_rdata  (io_rdata),
        .sw        (sw),
        .key       (key),
        .led       (led),
        .hex       (hex),
        .timer_irq (timer_irq)
    );

    initial forever #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h expected=%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_led    = '0;
        m_hex    = '0;
        m_cycle  = '0;
        m_flags  = '0;
        m_tload  = '0;
        m_tcount = '0;
        m_en     = 1'b0;
        m_auto   = 1'b0;
        m_exp    = 1'b0;
        sw_hist.delete();
        key_hist.delete();
        // Input history as seen at the last two edges; oldest entry is what software reads.
        repeat (2) begin
            sw_hist.push_back('0);
            key_hist.push_back('1);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [7:0] off;
        if (a[31:8] != 24'hFFFFFF) return 32'h0;
        off = {a[7:2], 2'b00};
        case (off)
            8'h80: return 32'(sw_hist[0]);
            8'h84: return 32'({m_flags, ~key_hist[0]});
            8'h88: return 32'(m_led);
            8'h8C: return 32'(m_hex);
            8'h90: return m_cycle;
`ifdef IO_TIMER_EN
            8'h94: return {29'h0, m_exp, m_auto, m_en};
            8'h98: return m_tload;
            8'h9C: return m_tcount;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        logic             wr;
        logic [7:0]       off;
        logic [KEY_W-1:0] old_p;
        logic [KEY_W-1:0] new_p;
        logic [KEY_W-1:0] clr;
        logic             expire;
        wr  = mwmem && (malu[31:8] == 24'hFFFFFF);
        off = {malu[7:2], 2'b00};
        m_cycle = m_cycle + 32'd1;
        old_p = ~key_hist[0];
        sw_hist.push_back(sw);
        void'(sw_hist.pop_front());
        key_hist.push_back(key);
        void'(key_hist.pop_front());
        new_p = ~key_hist[0];
        clr = (wr && off == 8'h84) ? mb[2*KEY_W-1:KEY_W] : '0;
        m_flags = (m_flags & ~clr) | (new_p & ~old_p);
        if (wr && off == 8'h88) m_led = mb[SW_W-1:0];
        if (wr && off == 8'h8C) m_hex = mb[23:0];
        expire = 1'b0;
`ifdef IO_TIMER_EN
        expire = m_en && (m_tcount == 32'h0);
        if (wr && off == 8'h94 && mb[2]) m_exp = 1'b0;
        if (expire) m_exp = 1'b1;
        if (m_en) begin
            if (m_tcount != 32'h0) m_tcount = m_tcount - 32'd1;
            else if (m_auto) m_tcount = m_tload;
            else m_en = 1'b0;
        end
        if (wr && off == 8'h94) begin
            m_en   = mb[0];
            m_auto = mb[1];
        end
        if (wr && off == 8'h98) begin
            m_tload  = mb;
            m_tcount = mb;
        end
`endif
        if (expire) m_exp = 1'b1;
    endtask

    // Compare all observable outputs, then take one clock edge.
    task automatic cyc();
        #1;
        check_eq("io_sel", 32'(io_sel), 32'(malu[31:8] == 24'hFFFFFF));
        check_eq("rdata", io_rdata, m_read(malu));
        check_eq("led", 32'(led), 32'(m_led));
        check_eq("hex", 32'(hex), 32'(m_hex));
        check_eq("timer_irq", 32'(timer_irq), 32'(m_exp));
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data);
        mwmem = 1'b1;
        malu  = {24'hFFFFFF, off};
        mb    = data;
        cyc();
        mwmem = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
        mwmem = 1'b0;
        malu  = {24'hFFFFFF, off};
        #1;
        check_eq(tag, io_rdata, exp);
    endtask

    task automatic rand_cycle();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7) malu = {24'hFFFFFF, 2'b10, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        else if (r < 8) malu = {24'hFFFFFF, 1'b0, 7'($urandom)};
        else malu = {8'($urandom_range(0, 254)), 24'($urandom)};
        mwmem = 1'($urandom_range(0, 1));
        mb    = $urandom;
        if (malu[7:2] == 6'h26) mb = $urandom_range(0, 6);
        if (malu[7:2] == 6'h25) mb = $urandom_range(0, 7);
        if ($urandom_range(0, 7) == 0) sw = SW_W'($urandom);
        if ($urandom_range(0, 3) == 0) key = KEY_W'($urandom);
        cyc();
    endtask

    initial begin
        int highs;
        model_reset();
        #11 resetn = 1'b1;
        malu = 32'hFFFFFF90;
        #1;
        check_eq("rst_led", 32'(led), 32'h0);
        check_eq("rst_hex", 32'(hex), 32'h0);
        check_eq("rst_irq", 32'(timer_irq), 32'h0);
        check_eq("rst_cycle", io_rdata, 32'h0);
        cyc();

        // Store then load
        wr(8'h88, 32'h3A5);
        check_eq("led_store", 32'(led), 32'h3A5);
        rd("led_load", 8'h88, 32'h0000_03A5);
        cyc();
        mwmem = 1'b1;
        malu  = 32'h0000_0088;
        mb    = 32'h111;
        #1;
        check_eq("outside_sel", 32'(io_sel), 32'h0);
        cyc();
        mwmem = 1'b0;
        check_eq("outside_led", 32'(led), 32'h3A5);

        // Switch synchronizer latency
        sw = SW_W'(10'h2AA);
        rd("sw_lat0", 8'h80, 32'h0);
        cyc();
        rd("sw_lat1", 8'h80, 32'h0);
        cyc();
        rd("sw_lat2", 8'h80, 32'h2AA);

        // Key edge flag and W1C
        key = 4'b1101;
        cyc();
        cyc();
        rd("key_edge", 8'h84, 32'h22);
        wr(8'h84, 32'h20);
        rd("key_w1c", 8'h84, 32'h02);
        key = 4'b1111;
        cyc();
        cyc();
        rd("key_rel", 8'h84, 32'h00);

`ifdef IO_TIMER_EN
        // One-shot countdown
        wr(8'h98, 32'd3);
        wr(8'h94, 32'h1);
        rd("tcnt3", 8'h9C, 32'd3);
        cyc();
        rd("tcnt2", 8'h9C, 32'd2);
        cyc();
        rd("tcnt1", 8'h9C, 32'd1);
        cyc();
        rd("tcnt0", 8'h9C, 32'd0);
        check_eq("irq_pre", 32'(timer_irq), 32'h0);
        cyc();
        check_eq("irq_oneshot", 32'(timer_irq), 32'h1);
        rd("tctrl_done", 8'h94, 32'h4);

        // W1C colliding with a fresh expiry
        wr(8'h94, 32'h4);
        check_eq("exp_clr", 32'(timer_irq), 32'h0);
        wr(8'h98, 32'd1);
        wr(8'h94, 32'h1);
        cyc();
        wr(8'h94, 32'h5);
        check_eq("exp_setwins", 32'(timer_irq), 32'h1);
        rd("tctrl_setwins", 8'h94, 32'h5);

        // Auto-reload with TLOAD=1: expiry every second edge
        wr(8'h94, 32'h4);
        wr(8'h98, 32'd1);
        wr(8'h94, 32'h3);
        highs = 0;
        mwmem = 1'b1;
        malu  = 32'hFFFFFF94;
        mb    = 32'h7;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (timer_irq) highs++;
        end
        mwmem = 1'b0;
        check_eq("auto_period", 32'(highs), 32'd4);
        wr(8'h94, 32'h4);
`else
        wr(8'h98, 32'd5);
        wr(8'h94, 32'h3);
        rd("tload_off", 8'h98, 32'h0);
        rd("tcount_off", 8'h9C, 32'h0);
        rd("tctrl_off", 8'h94, 32'h0);
        cyc();
        check_eq("irq_off", 32'(timer_irq), 32'h0);
`endif

        for (int i = 0; i < 400; i++) rand_cycle();

        // Asynchronous reset mid-operation
        mwmem = 1'b0;
        wr(8'h8C, 32'hABCDEF);
        #2 resetn = 1'b0;
        #1;
        check_eq("arst_led", 32'(led), 32'h0);
        check_eq("arst_hex", 32'(hex), 32'h0);
        check_eq("arst_irq", 32'(timer_irq), 32'h0);
        model_reset();
        sw  = '0;
        key = '1;
        @(posedge clock);
        #2 resetn = 1'b1;
        malu = 32'hFFFFFF90;
        #1;
        check_eq("arst_cycle", io_rdata, 32'h0);
        cyc();

        for (int i = 0; i < 150; i++) rand_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
